mult_hazard_ctrl: RTL and testbench

//  Sequences the serial multiplier in the 5-stage pipeline. Tracks one in-flight

---
 rtl/mult_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_mult_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_hazard_ctrl.sv
// Serial-multiplier sequencer: tracks one in-flight multiply, requests hazard stalls,
// and abandons hung ops. Optional stall counter enabled by MULT_HAZARD_CTRL_PERF_EN.
module mult_hazard_ctrl #(
    parameter int CW      = 6,
    parameter int TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          multd,
    input  logic          mfd,
    input  logic          stalld_ext,
    input  logic          prodv,
    output logic          multissue,
    output logic          multstall,
    output logic          busy,
    output logic          prodready,
    output logic [CW-1:0] cyclecnt,
    output logic          timeout,
    output logic [31:0]   stallcnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_BUSY,
        S_READY
    } state_t;

    localparam logic [CW-1:0] LP_TO_M1 = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LP_TO    = CW'(TIMEOUT);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    logic          w_busy;
    logic          w_stall;
    logic          w_issue;

    assign w_busy  = (r_state == S_EXEC) || (r_state == S_BUSY);
    assign w_stall = w_busy & (multd | mfd);
    // Nothing enters ID/EX while the block is held in reset.
    assign w_issue = reset & multd & ~stalld_ext & ~w_stall;

    assign multissue = w_issue;
    assign multstall = w_stall;
    assign busy      = w_busy;
    assign prodready = (r_state == S_READY);
    assign cyclecnt  = r_cnt;
    assign timeout   = r_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_READY: begin
                    if (w_issue) begin
                        r_state   <= S_EXEC;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_state <= S_BUSY;
                    r_cnt   <= CW'(1);
                end
                S_BUSY: begin
                    if (prodv) begin
                        r_state <= S_READY;
                    end else if (r_cnt == LP_TO_M1) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                        r_cnt     <= LP_TO;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MULT_HAZARD_CTRL_PERF_EN
    logic [31:0] r_stallcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallcnt <= '0;
        end else if (w_stall) begin
            r_stallcnt <= r_stallcnt + 32'd1;
        end
    end

    assign stallcnt = r_stallcnt;
`else
    assign stallcnt = 32'h0;
`endif

endmodule

// File: tb/tb_mult_hazard_ctrl.sv
// Scoreboard bench: a cycle-level occupancy model predicts outputs per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_mult_hazard_ctrl;

    localparam int CW      = 6;
    localparam int TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          multd = 1'b0;
    logic          mfd = 1'b0;
    logic          stalld_ext = 1'b0;
    logic          prodv = 1'b0;
    logic          multissue;
    logic          multstall;
    logic          busy;
    logic          prodready;
    logic [CW-1:0] cyclecnt;
    logic          timeout;
    logic [31:0]   stallcnt;

    mult_hazard_ctrl #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .multd(multd),
        .mfd(mfd),
        .stalld_ext(stalld_ext),
        .prodv(prodv),
        .multissue(multissue),
        .multstall(multstall),
        .busy(busy),
        .prodready(prodready),
        .cyclecnt(cyclecnt),
        .timeout(timeout),
        .stallcnt(stallcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        issue;
        logic        stall;
        logic        bsy;
        logic        rdy;
        logic        to;
        int          cnt;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: occupancy of the multiplier and elapsed busy cycles.
    bit          m_op;
    int          m_age;
    bit          m_prod;
    bit          m_to;
    int          m_cnt;
    logic [31:0] m_sc;

    function automatic void m_clear();
        m_op = 0; m_age = 0; m_prod = 0; m_to = 0; m_cnt = 0; m_sc = 0;
    endfunction

    function automatic bit m_stall(bit md, bit mf);
        return m_op && (md || mf);
    endfunction

    function automatic bit m_issue(bit rs, bit md, bit mf, bit se);
        return rs && md && !se && !m_stall(md, mf);
    endfunction

    function automatic void m_edge(bit rs, bit md, bit mf, bit se, bit pv);
        bit st, is;
        if (!rs) begin
            m_clear();
            return;
        end
        st = m_stall(md, mf);
        is = m_issue(rs, md, mf, se);
`ifdef MULT_HAZARD_CTRL_PERF_EN
        if (st) m_sc = m_sc + 32'd1;
`endif
        if (m_op) begin
            if (m_age >= 1 && pv) begin
                m_op = 0;
                m_prod = 1;
            end else if (m_age + 1 == TIMEOUT) begin
                m_op = 0;
                m_to = 1;
                m_cnt = TIMEOUT;
            end else begin
                m_age++;
                m_cnt = m_age;
            end
        end else if (is) begin
            m_op = 1; m_age = 0; m_cnt = 0; m_to = 0; m_prod = 0;
        end
    endfunction

    task automatic step(input bit md, input bit mf, input bit se,
                        input bit pv, input bit rs);
        exp_t e;
        @(posedge clk);
        #1;
        m_edge(reset, multd, mfd, stalld_ext, prodv);
        multd = md; mfd = mf; stalld_ext = se; prodv = pv; reset = rs;
        if (!rs) m_clear();
        e.issue = m_issue(rs, md, mf, se);
        e.stall = m_stall(md, mf);
        e.bsy   = m_op;
        e.rdy   = m_prod;
        e.to    = m_to;
        e.cnt   = m_cnt;
        e.sc    = m_sc;
        q.push_back(e);
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk1("multissue", multissue, e.issue);
            chk1("multstall", multstall, e.stall);
            chk1("busy", busy, e.bsy);
            chk1("prodready", prodready, e.rdy);
            chk1("timeout", timeout, e.to);
            checks++;
            if (int'(cyclecnt) != e.cnt) begin
                errors++;
                $display("FAIL cyclecnt t=%0t actual=%0d required=%0d",
                         $time, cyclecnt, e.cnt);
            end
            checks++;
            if (stallcnt !== e.sc) begin
                errors++;
                $display("FAIL stallcnt t=%0t actual=%0d required=%0d",
                         $time, stallcnt, e.sc);
            end
        end
    end

    initial begin
        int pv_div;
        m_clear();
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        // Issue, product reads stalled until prodv, then ready.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // External stall holds issue, then release.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1);
        // Hung multiplier: run to timeout with mult waiting.
        for (int i = 0; i < TIMEOUT + 3; i++) step(1, 0, 0, 0, 1);
        // Mid-op reset, then stray prodv.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        // Randomised phases with differing product latency.
        for (int ph = 0; ph < 6; ph++) begin
            pv_div = (ph % 3 == 0) ? 3 : (ph % 3 == 1) ? 25 : 1000;
            for (int i = 0; i < 500; i++) begin
                step(($urandom % 4) == 0, ($urandom % 3) == 0,
                     ($urandom % 5) == 0, ($urandom % pv_div) == 0,
                     ($urandom % 300) != 0);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
